// File: rtl/instr_decode.sv
// Decode stage: turns fetched words into registered operand/control bundles.
// Latency: one edge from acceptance to registered outputs; a NOP loads when nothing is accepted.
// Backpressure: instr_ready drops on a load-use hazard, in the branch shadow, on redirect and in reset.
module instr_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        pc_set,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [12:0] offset,
  output logic [31:0] pc,
  output logic [4:0]  rd,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {RUN, SHADOW} state_t;

  state_t      state, state_nxt;
  logic [6:0]  op_in;
  logic [31:0] rs1_val, rs2_val;
  logic        uses_rs2, hazard, accept;

  logic [6:0]  d_opcode, d_funct7;
  logic [2:0]  d_funct3;
  logic [31:0] d_op1, d_op2, d_pc;
  logic [12:0] d_offset;
  logic [4:0]  d_rd;
  logic        d_illegal;

  assign op_in    = instr[6:0];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  // Operand fetch with execute-stage forwarding; x0 is hard-wired to zero.
  always_comb begin
    rs1_val = rs1_data;
    rs2_val = rs2_data;
    if (rs1_addr == 5'd0)          rs1_val = 32'd0;
    else if (rs1_addr == wb_addr)  rs1_val = wb_data;
    if (rs2_addr == 5'd0)          rs2_val = 32'd0;
    else if (rs2_addr == wb_addr)  rs2_val = wb_data;
  end

  // Load-use hazard against the instruction now sitting in the output register.
  always_comb begin
    uses_rs2 = (op_in == OPC_OP) || (op_in == OPC_BRANCH);
    hazard   = instr_valid && (rd != 5'd0) &&
               ((rs1_addr == rd) || (uses_rs2 && (rs2_addr == rd)));
  end

  assign instr_ready = !rst && (state == RUN) && !pc_set && !hazard;
  assign accept      = instr_valid && instr_ready;

  // Next-state and next output bundle; defaults describe a NOP that keeps pc.
  always_comb begin
    state_nxt = RUN;
    d_opcode  = 7'd0;
    d_funct3  = 3'd0;
    d_funct7  = 7'd0;
    d_op1     = 32'd0;
    d_op2     = 32'd0;
    d_offset  = 13'd0;
    d_pc      = pc;
    d_rd      = 5'd0;
    d_illegal = 1'b0;
    if (accept) begin
      case (op_in)
        OPC_OP: begin
          d_opcode = op_in;
          d_funct3 = instr[14:12];
          d_funct7 = instr[31:25];
          d_op1    = rs1_val;
          d_op2    = rs2_val;
          d_pc     = instr_pc;
          d_rd     = instr[11:7];
        end
        OPC_OP_IMM: begin
          d_opcode = op_in;
          d_funct3 = instr[14:12];
          // Only shifts carry funct7; ADDI etc. must not alias onto SUB/SRA.
          if (instr[13:12] == 2'b01) d_funct7 = instr[31:25];
          d_op1    = rs1_val;
          d_op2    = {{20{instr[31]}}, instr[31:20]};
          d_pc     = instr_pc;
          d_rd     = instr[11:7];
        end
        OPC_BRANCH: begin
          d_opcode  = op_in;
          d_funct3  = instr[14:12];
          d_op1     = rs1_val;
          d_op2     = rs2_val;
          d_offset  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          d_pc      = instr_pc;
          state_nxt = SHADOW;
        end
        default: d_illegal = 1'b1;
      endcase
    end
  end

  // State register; SHADOW always falls back to RUN after one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Registered decode outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode  <= 7'd0;
      funct3  <= 3'd0;
      funct7  <= 7'd0;
      op1     <= 32'd0;
      op2     <= 32'd0;
      offset  <= 13'd0;
      pc      <= 32'd0;
      rd      <= 5'd0;
      illegal <= 1'b0;
    end else begin
      opcode  <= d_opcode;
      funct3  <= d_funct3;
      funct7  <= d_funct7;
      op1     <= d_op1;
      op2     <= d_op2;
      offset  <= d_offset;
      pc      <= d_pc;
      rd      <= d_rd;
      illegal <= d_illegal;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pc_set;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] op1, op2, pc;
  logic [12:0] offset;
  logic [4:0]  rd;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  instr_decode dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_addr(wb_addr), .wb_data(wb_data), .pc_set(pc_set),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .op1(op1), .op2(op2), .offset(offset), .pc(pc), .rd(rd),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] ipc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic [6:0]  e_opc;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [12:0] e_off;
    logic [31:0] e_pc;
    logic [4:0]  e_rd;
    logic        e_ill;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr = 32'd0; instr_pc = 32'd0; instr_valid = 1'b0;
    rs1_data = 32'd0; rs2_data = 32'd0; wb_addr = 5'd0; wb_data = 32'd0;
    pc_set = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h00500093, 32'h100, 32'hDEAD, 32'h0,   5'd0, 32'h77,
                7'h13, 3'd0, 7'h00, 32'h0,    32'h5,        13'h0,    32'h100, 5'd1, 1'b0};
    vecs[1] = '{32'hFFF00093, 32'h104, 32'h0,    32'h0,   5'd0, 32'h0,
                7'h13, 3'd0, 7'h00, 32'h0,    32'hFFFFFFFF, 13'h0,    32'h104, 5'd1, 1'b0};
    vecs[2] = '{32'h402081B3, 32'h108, 32'h10,   32'h3,   5'd0, 32'h0,
                7'h33, 3'd0, 7'h20, 32'h10,   32'h3,        13'h0,    32'h108, 5'd3, 1'b0};
    vecs[3] = '{32'h40335293, 32'h10C, 32'h80000000, 32'h0, 5'd6, 32'h1234,
                7'h13, 3'd5, 7'h20, 32'h1234, 32'h403,      13'h0,    32'h10C, 5'd5, 1'b0};
    vecs[4] = '{32'h40010113, 32'h110, 32'h55,   32'h0,   5'd3, 32'h99,
                7'h13, 3'd0, 7'h00, 32'h55,   32'h400,      13'h0,    32'h110, 5'd2, 1'b0};
    vecs[5] = '{32'h00208463, 32'h114, 32'h11,   32'h22,  5'd0, 32'h0,
                7'h63, 3'd0, 7'h00, 32'h11,   32'h22,       13'h8,    32'h114, 5'd0, 1'b0};
    vecs[6] = '{32'hFE419EE3, 32'h118, 32'h33,   32'h44,  5'd4, 32'hAAAA,
                7'h63, 3'd1, 7'h00, 32'h33,   32'hAAAA,     13'h1FFC, 32'h118, 5'd0, 1'b0};
    vecs[7] = '{32'h00000000, 32'h11C, 32'h0,    32'h0,   5'd0, 32'h0,
                7'h00, 3'd0, 7'h00, 32'h0,    32'h0,        13'h0,    32'h118, 5'd0, 1'b1};
    vecs[8] = '{32'h00002003, 32'h120, 32'h0,    32'h0,   5'd0, 32'h0,
                7'h00, 3'd0, 7'h00, 32'h0,    32'h0,        13'h0,    32'h118, 5'd0, 1'b1};

    // Reset: everything zero and no acceptance even with a valid word waiting.
    idle_inputs();
    rst = 1'b1;
    instr = 32'h00500093; instr_valid = 1'b1;
    #12;
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_opcode", {25'd0, opcode}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    tick();
    rst = 1'b0;
    instr_valid = 1'b0;
    tick();

    // Table: each vector accepted from an idle pipeline, then one bubble edge.
    for (int i = 0; i < 9; i++) begin
      instr = vecs[i].ins; instr_pc = vecs[i].ipc; instr_valid = 1'b1;
      rs1_data = vecs[i].r1; rs2_data = vecs[i].r2;
      wb_addr = vecs[i].wba; wb_data = vecs[i].wbd;
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, instr_ready}, 32'd1);
      chk($sformatf("v%0d_rs1a", i), {27'd0, rs1_addr}, {27'd0, vecs[i].ins[19:15]});
      tick();
      chk($sformatf("v%0d_opcode", i), {25'd0, opcode}, {25'd0, vecs[i].e_opc});
      chk($sformatf("v%0d_funct3", i), {29'd0, funct3}, {29'd0, vecs[i].e_f3});
      chk($sformatf("v%0d_funct7", i), {25'd0, funct7}, {25'd0, vecs[i].e_f7});
      chk($sformatf("v%0d_op1", i), op1, vecs[i].e_op1);
      chk($sformatf("v%0d_op2", i), op2, vecs[i].e_op2);
      chk($sformatf("v%0d_offset", i), {19'd0, offset}, {19'd0, vecs[i].e_off});
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_rd", i), {27'd0, rd}, {27'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].e_ill});
      idle_inputs();
      tick();
      chk($sformatf("v%0d_bubble_opc", i), {25'd0, opcode}, 32'd0);
      chk($sformatf("v%0d_bubble_ill", i), {31'd0, illegal}, 32'd0);
    end

    // Load-use hazard: ADDI x1 then ADD x3,x1,x2 stalls once, then forwards.
    instr = 32'h00500093; instr_pc = 32'h200; instr_valid = 1'b1;
    tick();
    instr = 32'h002081B3; instr_pc = 32'h204; rs2_data = 32'd7; rs1_data = 32'hBAD;
    #1;
    chk("haz_ready0", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("haz_nop_opc", {25'd0, opcode}, 32'd0);
    chk("haz_nop_rd", {27'd0, rd}, 32'd0);
    chk("haz_nop_pc", pc, 32'h200);
    wb_addr = 5'd1; wb_data = 32'd5;
    #1;
    chk("haz_ready1", {31'd0, instr_ready}, 32'd1);
    tick();
    chk("haz_op1", op1, 32'd5);
    chk("haz_op2", op2, 32'd7);
    chk("haz_rd", {27'd0, rd}, 32'd3);
    chk("haz_opc", {25'd0, opcode}, 32'h33);

    // rs2 field matching rd does not stall an OP_IMM (it is an immediate there).
    idle_inputs();
    instr = 32'h00500093; instr_pc = 32'h240; instr_valid = 1'b1;
    tick();
    instr = 32'h00110213; instr_pc = 32'h244;
    #1;
    chk("imm_noharz_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    chk("imm_noharz_rd", {27'd0, rd}, 32'd4);
    idle_inputs();
    tick();

    // Branch shadow then redirect: input dropped twice, fetch resumes after.
    instr = 32'h00208463; instr_pc = 32'h300; instr_valid = 1'b1;
    tick();
    chk("br_offset", {19'd0, offset}, 32'd8);
    chk("br_rd", {27'd0, rd}, 32'd0);
    instr = 32'h00700393; instr_pc = 32'h304;
    #1;
    chk("br_shadow_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("br_shadow_nop", {25'd0, opcode}, 32'd0);
    pc_set = 1'b1;
    #1;
    chk("br_pcset_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("br_pcset_nop", {25'd0, opcode}, 32'd0);
    chk("br_pcset_pc", pc, 32'h300);
    pc_set = 1'b0; instr_pc = 32'h400;
    #1;
    chk("br_resume_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    chk("br_resume_opc", {25'd0, opcode}, 32'h13);
    chk("br_resume_pc", pc, 32'h400);
    chk("br_resume_op2", op2, 32'd7);
    idle_inputs();
    tick();

    // Reset asserted inside the branch shadow aborts it.
    instr = 32'h00208463; instr_pc = 32'h500; instr_valid = 1'b1;
    tick();
    chk("rsh_br_opc", {25'd0, opcode}, 32'h63);
    rst = 1'b1;
    #1;
    chk("rsh_opc", {25'd0, opcode}, 32'd0);
    chk("rsh_offset", {19'd0, offset}, 32'd0);
    chk("rsh_pc", pc, 32'd0);
    chk("rsh_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    rst = 1'b0;
    instr = 32'h00700393; instr_pc = 32'h600;
    #1;
    chk("rsh_after_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    chk("rsh_after_opc", {25'd0, opcode}, 32'h13);
    chk("rsh_after_pc", pc, 32'h600);

    idle_inputs();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-002 Ports SHALL be as follows, one per line: name  direction  width  meaning:
  clk  in  1  clock, rising edge.
  rst  in  1  async reset, active-high.
  instr  in  32  fetched instruction word.
  instr_pc  in  32  address of instr.
  instr_valid  in  1  instr/instr_pc valid.
  instr_ready  out  1  decode accepts instr this cycle (combinational).
  rs1_addr  out  5  regfile read address 1 = instr[19:15] (combinational).
  rs2_addr  out  5  regfile read address 2 = instr[24:20] (combinational).
  rs1_data  in  32  regfile read data 1 (combinational regfile).
  rs2_data  in  32  regfile read data 2.
  wb_addr  in  5  execute-stage destination register; 0 = none.
  wb_data  in  32  execute-stage result.
  pc_set  in  1  execute-stage branch taken (redirect).
  opcode  out  7  registered; 0 = NOP bubble.
  funct3  out  3  registered.
  funct7  out  7  registered.
  op1  out  32  registered operand 1.
  op2  out  32  registered operand 2.
  offset  out  13  registered branch offset.
  pc  out  32  registered instruction address.
  rd  out  5  registered destination.
  illegal  out  1  registered one-cycle pulse, unsupported opcode accepted.

Function
REQ-003 An instruction SHALL be accepted on a rising edge where instr_valid=1 and instr_ready=1; accepted fields SHALL appear on the registered outputs after exactly one edge.
REQ-004 Any edge without acceptance SHALL load a NOP: opcode=0, rd=0, funct3/funct7/op1/op2/offset=0, pc unchanged, illegal=0.
REQ-005 Operand source: rsN value = wb_data when rsN_addr==wb_addr and wb_addr!=0; else rsN_data; register x0 SHALL always read 0.
REQ-006 OP (0110011): op1=rs1, op2=rs2, funct7=instr[31:25], rd=instr[11:7], offset=0.
REQ-007 OP_IMM (0010011): op1=rs1, op2=sign-extended instr[31:20], rd=instr[11:7]; funct7=instr[31:25] when funct3 is 001 or 101, else 0 (ADDI never decodes as SUB).
REQ-008 BRANCH (1100011): op1=rs1, op2=rs2, rd=0, funct7=0, offset={instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
REQ-009 Any other opcode accepted SHALL load a NOP and set illegal=1 for one cycle.
REQ-010 Hazard: instr_ready SHALL be 0 when instr_valid=1, registered rd!=0, and instr[19:15] or instr[24:20] (rs2 only for OP/BRANCH) equals registered rd; one NOP is issued, then REQ-005 forwarding supplies the value.
REQ-011 State machine states RUN and SHADOW: accepting a BRANCH moves RUN->SHADOW; SHADOW SHALL return to RUN after one edge; instr_ready=0 in SHADOW.
REQ-012 instr_ready = !rst and state==RUN and !pc_set and no hazard.
REQ-013 pc_set=1 at an edge SHALL discard instr, load a NOP and force state RUN; pc_set has priority over hazard and SHADOW.
REQ-014 Branch sequence: branch issued edge n; NOP issued edge n+1; if pc_set=1 at edge n+2, NOP issued and input dropped; redirected fetch accepted at edge n+3 earliest.

Reset
REQ-015 While rst=1, all registered outputs SHALL be 0, state SHALL be RUN, instr_ready SHALL be 0.
REQ-016 Reset asserted mid-hazard or in SHADOW SHALL abort it; first acceptance possible on the first edge after rst falls.

Verification
REQ-017 ADDI x1,x0,5 (0x00500093), pc 0x100, valid -> next cycle opcode=0x13, op1=0, op2=5, rd=1, funct7=0, pc=0x100.
REQ-018 ADDI x1,x0,-1 (0xFFF00093) -> op2=0xFFFFFFFF, funct7=0.
REQ-019 ADDI x1 then ADD x3,x1,x2 (0x002081B3), rs2_data=7 -> instr_ready=0 one cycle, NOP issued; then wb_addr=1, wb_data=5 -> op1=5, op2=7, rd=3.
REQ-020 SUB x3,x1,x2 (0x402081B3) -> funct7=0x20, opcode=0x33.
REQ-021 BEQ x1,x2,+8 (0x00208463) -> offset=8, rd=0, next edge NOP with instr_ready=0; pc_set=1 next cycle -> input dropped, NOP; acceptance resumes after.
REQ-022 instr=0x00000000 valid -> opcode=0, illegal pulse 1 cycle; rst asserted while in SHADOW -> outputs 0, instr_ready=0.
